// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: shares one combinational ALU between two requesters.
// One operation is in flight at a time. IDLE arbitrates round-robin and
// latches the winner's operands, EXEC drives them into the ALU and captures
// the result, and RESP hands the result back to the owner.
module alu_share_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int FUNC_WIDTH = 5
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  R0_VALID,
    output logic                  R0_READY,
    input  logic [DATA_WIDTH-1:0] R0_PC,
    input  logic [DATA_WIDTH-1:0] R0_RS1,
    input  logic [DATA_WIDTH-1:0] R0_RS2,
    input  logic [DATA_WIDTH-1:0] R0_IMM,
    input  logic [FUNC_WIDTH-1:0] R0_CTRL,
    input  logic                  R0_MUX1,
    input  logic                  R0_MUX2,
    output logic                  R0_RSP_VALID,
    input  logic                  R0_RSP_READY,
    output logic [DATA_WIDTH-1:0] R0_RSP_DATA,
    input  logic                  R1_VALID,
    output logic                  R1_READY,
    input  logic [DATA_WIDTH-1:0] R1_PC,
    input  logic [DATA_WIDTH-1:0] R1_RS1,
    input  logic [DATA_WIDTH-1:0] R1_RS2,
    input  logic [DATA_WIDTH-1:0] R1_IMM,
    input  logic [FUNC_WIDTH-1:0] R1_CTRL,
    input  logic                  R1_MUX1,
    input  logic                  R1_MUX2,
    output logic                  R1_RSP_VALID,
    input  logic                  R1_RSP_READY,
    output logic [DATA_WIDTH-1:0] R1_RSP_DATA,
    output logic [DATA_WIDTH-1:0] ALU_PC,
    output logic [DATA_WIDTH-1:0] ALU_RS1,
    output logic [DATA_WIDTH-1:0] ALU_RS2,
    output logic [DATA_WIDTH-1:0] ALU_IMM,
    output logic [FUNC_WIDTH-1:0] ALU_CTRL,
    output logic                  ALU_MUX1,
    output logic                  ALU_MUX2,
    input  logic [DATA_WIDTH-1:0] ALU_RESULT,
    output logic                  BUSY
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // Requester ports gathered into arrays so the grant can index them
    logic [1:0]            req_valid;
    logic [1:0]            rsp_ready;
    logic [1:0]            req_ready;
    logic [1:0]            rsp_valid;
    logic [DATA_WIDTH-1:0] req_pc  [2];
    logic [DATA_WIDTH-1:0] req_rs1 [2];
    logic [DATA_WIDTH-1:0] req_rs2 [2];
    logic [DATA_WIDTH-1:0] req_imm [2];
    logic [FUNC_WIDTH-1:0] req_ctrl[2];
    logic [1:0]            req_mux1;
    logic [1:0]            req_mux2;

    assign req_valid = {R1_VALID, R0_VALID};
    assign rsp_ready = {R1_RSP_READY, R0_RSP_READY};
    assign req_pc[0]   = R0_PC;   assign req_pc[1]   = R1_PC;
    assign req_rs1[0]  = R0_RS1;  assign req_rs1[1]  = R1_RS1;
    assign req_rs2[0]  = R0_RS2;  assign req_rs2[1]  = R1_RS2;
    assign req_imm[0]  = R0_IMM;  assign req_imm[1]  = R1_IMM;
    assign req_ctrl[0] = R0_CTRL; assign req_ctrl[1] = R1_CTRL;
    assign req_mux1 = {R1_MUX1, R0_MUX1};
    assign req_mux2 = {R1_MUX2, R0_MUX2};

    state_t                state_q, state_d;
    logic                  last_q, last_d;
    logic                  owner_q, owner_d;
    logic [DATA_WIDTH-1:0] pc_q, pc_d, rs1_q, rs1_d, rs2_q, rs2_d, imm_q, imm_d;
    logic [FUNC_WIDTH-1:0] ctrl_q, ctrl_d;
    logic                  mux1_q, mux1_d, mux2_q, mux2_d;
    logic [DATA_WIDTH-1:0] result_q, result_d;

    // Round-robin: on a tie the requester that did not win last time goes;
    // a lone requester is granted directly.
    logic grant_any;
    logic grant_idx;
    assign grant_any = |req_valid;
    assign grant_idx = (&req_valid) ? ~last_q : req_valid[1];

    // Per-requester handshake outputs
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_req
            assign req_ready[gi] = (state_q == ST_IDLE) && grant_any && (grant_idx == 1'(gi));
            assign rsp_valid[gi] = (state_q == ST_RESP) && (owner_q == 1'(gi));
        end
    endgenerate

    assign R0_READY     = req_ready[0];
    assign R1_READY     = req_ready[1];
    assign R0_RSP_VALID = rsp_valid[0];
    assign R1_RSP_VALID = rsp_valid[1];
    assign R0_RSP_DATA  = result_q;
    assign R1_RSP_DATA  = result_q;
    assign ALU_PC   = pc_q;
    assign ALU_RS1  = rs1_q;
    assign ALU_RS2  = rs2_q;
    assign ALU_IMM  = imm_q;
    assign ALU_CTRL = ctrl_q;
    assign ALU_MUX1 = mux1_q;
    assign ALU_MUX2 = mux2_q;
    assign BUSY     = (state_q != ST_IDLE);

    // Next-state and datapath load decisions
    always_comb begin
        state_d  = state_q;
        last_d   = last_q;
        owner_d  = owner_q;
        pc_d     = pc_q;
        rs1_d    = rs1_q;
        rs2_d    = rs2_q;
        imm_d    = imm_q;
        ctrl_d   = ctrl_q;
        mux1_d   = mux1_q;
        mux2_d   = mux2_q;
        result_d = result_q;
        case (state_q)
            ST_IDLE: begin
                if (grant_any) begin
                    pc_d    = req_pc[grant_idx];
                    rs1_d   = req_rs1[grant_idx];
                    rs2_d   = req_rs2[grant_idx];
                    imm_d   = req_imm[grant_idx];
                    ctrl_d  = req_ctrl[grant_idx];
                    mux1_d  = req_mux1[grant_idx];
                    mux2_d  = req_mux2[grant_idx];
                    owner_d = grant_idx;
                    last_d  = grant_idx;
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                result_d = ALU_RESULT;
                state_d  = ST_RESP;
            end
            ST_RESP: begin
                // Only the owner's ready releases the response
                if (rsp_ready[owner_q]) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers; reset abandons any in-flight operation
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q  <= ST_IDLE;
            last_q   <= 1'b1;
            owner_q  <= 1'b0;
            pc_q     <= '0;
            rs1_q    <= '0;
            rs2_q    <= '0;
            imm_q    <= '0;
            ctrl_q   <= '0;
            mux1_q   <= 1'b0;
            mux2_q   <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            last_q   <= last_d;
            owner_q  <= owner_d;
            pc_q     <= pc_d;
            rs1_q    <= rs1_d;
            rs2_q    <= rs2_d;
            imm_q    <= imm_d;
            ctrl_q   <= ctrl_d;
            mux1_q   <= mux1_d;
            mux2_q   <= mux2_d;
            result_q <= result_d;
        end
    end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Testbench for alu_share_arbiter: a small ALU model closes the loop and a
// scoreboard queue holds the expected result of every accepted request.
module tb_alu_share_arbiter;

    logic        CLK = 1'b0;
    logic        RST;
    logic        R0_VALID, R0_READY, R0_MUX1, R0_MUX2, R0_RSP_VALID, R0_RSP_READY;
    logic [31:0] R0_PC, R0_RS1, R0_RS2, R0_IMM, R0_RSP_DATA;
    logic [4:0]  R0_CTRL;
    logic        R1_VALID, R1_READY, R1_MUX1, R1_MUX2, R1_RSP_VALID, R1_RSP_READY;
    logic [31:0] R1_PC, R1_RS1, R1_RS2, R1_IMM, R1_RSP_DATA;
    logic [4:0]  R1_CTRL;
    logic [31:0] ALU_PC, ALU_RS1, ALU_RS2, ALU_IMM, ALU_RESULT;
    logic [4:0]  ALU_CTRL;
    logic        ALU_MUX1, ALU_MUX2, BUSY;

    typedef struct packed {
        logic        owner;
        logic [31:0] data;
    } sb_t;

    sb_t sb_q[$];
    int  pass_cnt = 0;
    int  chk_cnt  = 0;

    alu_share_arbiter #(.DATA_WIDTH(32), .FUNC_WIDTH(5)) dut (
        .CLK(CLK), .RST(RST),
        .R0_VALID(R0_VALID), .R0_READY(R0_READY), .R0_PC(R0_PC), .R0_RS1(R0_RS1),
        .R0_RS2(R0_RS2), .R0_IMM(R0_IMM), .R0_CTRL(R0_CTRL), .R0_MUX1(R0_MUX1),
        .R0_MUX2(R0_MUX2), .R0_RSP_VALID(R0_RSP_VALID), .R0_RSP_READY(R0_RSP_READY),
        .R0_RSP_DATA(R0_RSP_DATA),
        .R1_VALID(R1_VALID), .R1_READY(R1_READY), .R1_PC(R1_PC), .R1_RS1(R1_RS1),
        .R1_RS2(R1_RS2), .R1_IMM(R1_IMM), .R1_CTRL(R1_CTRL), .R1_MUX1(R1_MUX1),
        .R1_MUX2(R1_MUX2), .R1_RSP_VALID(R1_RSP_VALID), .R1_RSP_READY(R1_RSP_READY),
        .R1_RSP_DATA(R1_RSP_DATA),
        .ALU_PC(ALU_PC), .ALU_RS1(ALU_RS1), .ALU_RS2(ALU_RS2), .ALU_IMM(ALU_IMM),
        .ALU_CTRL(ALU_CTRL), .ALU_MUX1(ALU_MUX1), .ALU_MUX2(ALU_MUX2),
        .ALU_RESULT(ALU_RESULT), .BUSY(BUSY)
    );

    always #5 CLK = ~CLK;

    // ALU model: A = MUX1 ? PC : RS1, B = MUX2 ? IMM : RS2; 0 add, 1 sub, else xor
    function automatic logic [31:0] alu_model(input logic [31:0] pc, rs1, rs2, imm,
                                              input logic [4:0] ctrl, input logic m1, m2);
        logic [31:0] a, b;
        a = m1 ? pc : rs1;
        b = m2 ? imm : rs2;
        case (ctrl)
            5'd0:    return a + b;
            5'd1:    return a - b;
            default: return a ^ b;
        endcase
    endfunction

    assign ALU_RESULT = alu_model(ALU_PC, ALU_RS1, ALU_RS2, ALU_IMM, ALU_CTRL, ALU_MUX1, ALU_MUX2);

    // Push the expected result whenever a request handshake will complete at the next edge
    always @(negedge CLK) begin
        sb_t e;
        if (RST === 1'b0) begin
            if (R0_VALID && R0_READY) begin
                e.owner = 1'b0;
                e.data  = alu_model(R0_PC, R0_RS1, R0_RS2, R0_IMM, R0_CTRL, R0_MUX1, R0_MUX2);
                sb_q.push_back(e);
            end
            if (R1_VALID && R1_READY) begin
                e.owner = 1'b1;
                e.data  = alu_model(R1_PC, R1_RS1, R1_RS2, R1_IMM, R1_CTRL, R1_MUX1, R1_MUX2);
                sb_q.push_back(e);
            end
        end
    end

    task automatic set_r0(input logic [31:0] pc, rs1, rs2, imm, input logic [4:0] ctrl,
                          input logic m1, m2);
        R0_PC = pc; R0_RS1 = rs1; R0_RS2 = rs2; R0_IMM = imm;
        R0_CTRL = ctrl; R0_MUX1 = m1; R0_MUX2 = m2;
    endtask

    task automatic set_r1(input logic [31:0] pc, rs1, rs2, imm, input logic [4:0] ctrl,
                          input logic m1, m2);
        R1_PC = pc; R1_RS1 = rs1; R1_RS2 = rs2; R1_IMM = imm;
        R1_CTRL = ctrl; R1_MUX1 = m1; R1_MUX2 = m2;
    endtask

    task automatic test_reset;
        RST = 1'b1;
        R0_VALID = 0; R1_VALID = 0; R0_RSP_READY = 0; R1_RSP_READY = 0;
        set_r0(32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0);
        set_r1(32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0);
        repeat (2) @(posedge CLK);
        #1;
        chk_cnt++; if (BUSY !== 1'b0) $display("FAIL reset_busy: got %b exp 0", BUSY); else pass_cnt++;
        chk_cnt++; if ({R1_RSP_VALID, R0_RSP_VALID} !== 2'b00) $display("FAIL reset_rsp_valid: got %b%b exp 00", R1_RSP_VALID, R0_RSP_VALID); else pass_cnt++;
        chk_cnt++; if ({ALU_PC, ALU_RS1, ALU_RS2, ALU_IMM} !== 128'h0) $display("FAIL reset_alu_operands: got %h %h %h %h exp 0", ALU_PC, ALU_RS1, ALU_RS2, ALU_IMM); else pass_cnt++;
        chk_cnt++; if ({ALU_CTRL, ALU_MUX1, ALU_MUX2} !== 7'h0) $display("FAIL reset_alu_ctrl: got %h %b %b exp 0", ALU_CTRL, ALU_MUX1, ALU_MUX2); else pass_cnt++;
        chk_cnt++; if ({R0_RSP_DATA, R1_RSP_DATA} !== 64'h0) $display("FAIL reset_rsp_data: got %h %h exp 0", R0_RSP_DATA, R1_RSP_DATA); else pass_cnt++;
        chk_cnt++; if ({R1_READY, R0_READY} !== 2'b00) $display("FAIL reset_ready_idle: got %b%b exp 00", R1_READY, R0_READY); else pass_cnt++;
        // LAST resets to 1, so a tie must grant R0
        R0_VALID = 1; R1_VALID = 1;
        #1;
        chk_cnt++; if ({R1_READY, R0_READY} !== 2'b01) $display("FAIL reset_first_tie: got R1/R0 ready %b%b exp 01", R1_READY, R0_READY); else pass_cnt++;
        R0_VALID = 0; R1_VALID = 0;
        @(posedge CLK); #1;
        RST = 1'b0;
        @(posedge CLK); #1;
    endtask

    task automatic test_single;
        int  rdy_cnt = 0, acc_i = -1, rsp_i = -1, rsp_cnt = 0;
        bit  r1_seen = 0, acc_now;
        sb_t e;
        set_r0(32'h0, 32'd20, 32'd30, 32'h0, 5'd0, 1'b0, 1'b0);
        R0_RSP_READY = 1; R1_RSP_READY = 1; R0_VALID = 1;
        for (int i = 0; i < 12; i++) begin
            @(negedge CLK);
            acc_now = R0_READY;
            if (R0_READY) begin rdy_cnt++; acc_i = i; end
            if (R1_RSP_VALID) r1_seen = 1;
            if (R0_RSP_VALID && rsp_i < 0) rsp_i = i;
            if (R0_RSP_VALID && R0_RSP_READY) begin
                rsp_cnt++;
                chk_cnt++;
                if (sb_q.size() == 0) $display("FAIL single_rsp: unexpected response data %h", R0_RSP_DATA);
                else begin
                    e = sb_q.pop_front();
                    if ({1'b0, R0_RSP_DATA} !== {e.owner, e.data} || R0_RSP_DATA !== 32'd50)
                        $display("FAIL single_rsp: got owner 0 data %0d exp owner %0d data %0d", R0_RSP_DATA, e.owner, e.data);
                    else pass_cnt++;
                end
            end
            @(posedge CLK); #1;
            if (acc_now) R0_VALID = 0;
        end
        chk_cnt++; if (rdy_cnt !== 1) $display("FAIL single_ready_cycles: got %0d exp 1", rdy_cnt); else pass_cnt++;
        chk_cnt++; if (rsp_i - acc_i !== 2) $display("FAIL single_latency: got %0d exp 2", rsp_i - acc_i); else pass_cnt++;
        chk_cnt++; if (r1_seen !== 1'b0) $display("FAIL single_r1_rsp_valid: got %b exp 0", r1_seen); else pass_cnt++;
        chk_cnt++; if (rsp_cnt !== 1) $display("FAIL single_rsp_count: got %0d exp 1", rsp_cnt); else pass_cnt++;
    endtask

    task automatic test_contention;
        int  grants[$], accs[$];
        int  rsp_cnt = 0;
        sb_t e;
        set_r0(32'h0, 32'd1, 32'd2, 32'h0, 5'd0, 1'b0, 1'b0);
        set_r1(32'h0, 32'd10, 32'd20, 32'h0, 5'd0, 1'b0, 1'b0);
        R0_RSP_READY = 1; R1_RSP_READY = 1; R0_VALID = 1; R1_VALID = 1;
        for (int i = 0; i < 20; i++) begin
            @(negedge CLK);
            if (R0_READY) begin grants.push_back(0); accs.push_back(i); end
            if (R1_READY) begin grants.push_back(1); accs.push_back(i); end
            if (R0_RSP_VALID || R1_RSP_VALID) begin
                rsp_cnt++;
                chk_cnt++;
                if (sb_q.size() == 0) $display("FAIL contention_rsp: unexpected response r0v %b r1v %b", R0_RSP_VALID, R1_RSP_VALID);
                else begin
                    e = sb_q.pop_front();
                    if ({R1_RSP_VALID, R0_RSP_VALID} !== (e.owner ? 2'b10 : 2'b01) || R0_RSP_DATA !== e.data)
                        $display("FAIL contention_rsp: got r1v/r0v %b%b data %0d exp owner %0d data %0d", R1_RSP_VALID, R0_RSP_VALID, R0_RSP_DATA, e.owner, e.data);
                    else pass_cnt++;
                end
            end
            @(posedge CLK); #1;
            if (grants.size() >= 4) begin R0_VALID = 0; R1_VALID = 0; end
        end
        chk_cnt++; if (grants.size() !== 4) $display("FAIL contention_grants: got %0d grants exp 4", grants.size()); else pass_cnt++;
        for (int j = 0; j < grants.size() && j < 4; j++) begin
            chk_cnt++; if (grants[j] !== (j % 2)) $display("FAIL contention_order[%0d]: got R%0d exp R%0d", j, grants[j], j % 2); else pass_cnt++;
            if (j > 0) begin
                chk_cnt++; if (accs[j] - accs[j-1] !== 3) $display("FAIL contention_spacing[%0d]: got %0d exp 3", j, accs[j] - accs[j-1]); else pass_cnt++;
            end
        end
        chk_cnt++; if (rsp_cnt !== 4) $display("FAIL contention_rsp_count: got %0d exp 4", rsp_cnt); else pass_cnt++;
    endtask

    task automatic test_backpressure;
        int  r1_acc = -1, r0_acc = -1, done_i = -1, held = 0, r0_rsp = 0;
        sb_t e;
        set_r1(32'h100, 32'h0, 32'h0, 32'h24, 5'd0, 1'b1, 1'b1);
        set_r0(32'h0, 32'd100, 32'd7, 32'h0, 5'd1, 1'b0, 1'b0);
        R1_RSP_READY = 0; R0_RSP_READY = 1; R1_VALID = 1;
        for (int i = 0; i < 24; i++) begin
            @(negedge CLK);
            if (R1_READY) r1_acc = i;
            if (R0_READY && r0_acc < 0) r0_acc = i;
            if (R1_RSP_VALID && !R1_RSP_READY) begin
                held++;
                chk_cnt++;
                if (sb_q.size() == 0 || R1_RSP_DATA !== sb_q[0].data) $display("FAIL bp_hold_data: got %h exp %h", R1_RSP_DATA, (sb_q.size() == 0) ? 32'hx : sb_q[0].data);
                else pass_cnt++;
            end
            if ((R1_RSP_VALID && R1_RSP_READY) || (R0_RSP_VALID && R0_RSP_READY)) begin
                if (R1_RSP_VALID) done_i = i; else r0_rsp++;
                chk_cnt++;
                if (sb_q.size() == 0) $display("FAIL bp_rsp: unexpected response data %h", R0_RSP_DATA);
                else begin
                    e = sb_q.pop_front();
                    if (e.owner !== R1_RSP_VALID || R0_RSP_DATA !== e.data)
                        $display("FAIL bp_rsp: got owner %b data %h exp owner %b data %h", R1_RSP_VALID, R0_RSP_DATA, e.owner, e.data);
                    else pass_cnt++;
                end
            end
            @(posedge CLK); #1;
            if (i == r1_acc) begin R1_VALID = 0; R0_VALID = 1; end
            if (held == 5) R1_RSP_READY = 1;
            if (i == r0_acc) R0_VALID = 0;
        end
        chk_cnt++; if (held !== 5) $display("FAIL bp_held_cycles: got %0d exp 5", held); else pass_cnt++;
        chk_cnt++; if (r0_acc - done_i !== 1) $display("FAIL bp_r0_accept_gap: got %0d exp 1", r0_acc - done_i); else pass_cnt++;
        chk_cnt++; if (r0_rsp !== 1) $display("FAIL bp_r0_rsp_count: got %0d exp 1", r0_rsp); else pass_cnt++;
        R1_RSP_READY = 1;
    endtask

    task automatic test_nonowner;
        int  resp_cycles = 0, rsp_cnt = 0;
        bit  acc_now;
        sb_t e;
        set_r0(32'h0, 32'h1234, 32'h00FF, 32'h0, 5'd2, 1'b0, 1'b0);
        R0_RSP_READY = 0; R1_RSP_READY = 1; R0_VALID = 1;
        for (int i = 0; i < 16; i++) begin
            @(negedge CLK);
            acc_now = R0_READY;
            if (R0_RSP_VALID && !R0_RSP_READY) begin
                resp_cycles++;
                chk_cnt++;
                if ({BUSY, R0_RSP_VALID, R1_RSP_VALID} !== 3'b110) $display("FAIL nonowner_hold: got busy/r0v/r1v %b%b%b exp 110", BUSY, R0_RSP_VALID, R1_RSP_VALID);
                else pass_cnt++;
            end
            if (R0_RSP_VALID && R0_RSP_READY) begin
                rsp_cnt++;
                chk_cnt++;
                if (sb_q.size() == 0) $display("FAIL nonowner_rsp: unexpected response %h", R0_RSP_DATA);
                else begin
                    e = sb_q.pop_front();
                    if (e.owner !== 1'b0 || R0_RSP_DATA !== e.data) $display("FAIL nonowner_rsp: got %h exp owner %0d data %h", R0_RSP_DATA, e.owner, e.data);
                    else pass_cnt++;
                end
            end
            @(posedge CLK); #1;
            if (acc_now) R0_VALID = 0;
            if (resp_cycles == 4) R0_RSP_READY = 1;
        end
        chk_cnt++; if (rsp_cnt !== 1) $display("FAIL nonowner_rsp_count: got %0d exp 1", rsp_cnt); else pass_cnt++;
    endtask

    task automatic test_wrap;
        int  rsp_cnt = 0;
        bit  acc_now;
        sb_t e;
        set_r1(32'h0, 32'hFFFF_FFFF, 32'h1, 32'h0, 5'd0, 1'b0, 1'b0);
        R1_RSP_READY = 1; R0_RSP_READY = 1; R1_VALID = 1;
        for (int i = 0; i < 10; i++) begin
            @(negedge CLK);
            acc_now = R1_READY;
            if (R1_RSP_VALID && R1_RSP_READY) begin
                rsp_cnt++;
                chk_cnt++;
                if (sb_q.size() == 0) $display("FAIL wrap_rsp: unexpected response %h", R1_RSP_DATA);
                else begin
                    e = sb_q.pop_front();
                    if (e.owner !== 1'b1 || R1_RSP_DATA !== 32'h0000_0000) $display("FAIL wrap_rsp: got %h exp 00000000", R1_RSP_DATA);
                    else pass_cnt++;
                end
            end
            @(posedge CLK); #1;
            if (acc_now) R1_VALID = 0;
        end
        chk_cnt++; if (rsp_cnt !== 1) $display("FAIL wrap_rsp_count: got %0d exp 1", rsp_cnt); else pass_cnt++;
    endtask

    task automatic test_reset_mid;
        bit  in_exec = 0, a0, a1;
        int  first_grant = -1, rsp_cnt = 0, stale = 0;
        sb_t e;
        // R0 alone so LAST becomes 0; without the reset a later tie would go to R1
        set_r0(32'h0, 32'd5, 32'd5, 32'h0, 5'd0, 1'b0, 1'b0);
        R0_RSP_READY = 1; R1_RSP_READY = 1; R0_VALID = 1;
        for (int i = 0; i < 6 && !in_exec; i++) begin
            @(negedge CLK);
            if (BUSY) in_exec = 1;
            else begin @(posedge CLK); #1; end
        end
        R0_VALID = 0;
        RST = 1'b1;
        #1;
        chk_cnt++; if (in_exec !== 1'b1) $display("FAIL rstmid_reach_exec: got %b exp 1", in_exec); else pass_cnt++;
        chk_cnt++; if ({BUSY, R0_RSP_VALID, R1_RSP_VALID} !== 3'b000) $display("FAIL rstmid_flags: got busy/r0v/r1v %b%b%b exp 000", BUSY, R0_RSP_VALID, R1_RSP_VALID); else pass_cnt++;
        chk_cnt++; if ({ALU_PC, ALU_RS1, ALU_RS2, ALU_IMM, ALU_CTRL, ALU_MUX1, ALU_MUX2} !== 135'h0) $display("FAIL rstmid_alu: got rs1 %h rs2 %h ctrl %h exp 0", ALU_RS1, ALU_RS2, ALU_CTRL); else pass_cnt++;
        sb_q.delete();
        set_r0(32'h0, 32'd7, 32'd8, 32'h0, 5'd2, 1'b0, 1'b0);
        set_r1(32'h0, 32'd3, 32'd4, 32'h0, 5'd0, 1'b0, 1'b0);
        R0_VALID = 1; R1_VALID = 1;
        @(posedge CLK); #1;
        RST = 1'b0;
        for (int i = 0; i < 16; i++) begin
            @(negedge CLK);
            a0 = R0_READY; a1 = R1_READY;
            if (first_grant < 0 && (a0 || a1)) first_grant = a1 ? 1 : 0;
            if ((R0_RSP_VALID || R1_RSP_VALID) && first_grant < 0) stale++;
            if (R0_RSP_VALID || R1_RSP_VALID) begin
                rsp_cnt++;
                chk_cnt++;
                if (sb_q.size() == 0) $display("FAIL rstmid_rsp: unexpected response data %h", R0_RSP_DATA);
                else begin
                    e = sb_q.pop_front();
                    if (e.owner !== R1_RSP_VALID || R0_RSP_DATA !== e.data) $display("FAIL rstmid_rsp: got owner %b data %h exp owner %b data %h", R1_RSP_VALID, R0_RSP_DATA, e.owner, e.data);
                    else pass_cnt++;
                end
            end
            @(posedge CLK); #1;
            if (a0) R0_VALID = 0;
            if (a1) R1_VALID = 0;
        end
        chk_cnt++; if (first_grant !== 0) $display("FAIL rstmid_first_grant: got R%0d exp R0", first_grant); else pass_cnt++;
        chk_cnt++; if (stale !== 0) $display("FAIL rstmid_stale_rsp: got %0d exp 0", stale); else pass_cnt++;
        chk_cnt++; if (rsp_cnt !== 2) $display("FAIL rstmid_rsp_count: got %0d exp 2", rsp_cnt); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_contention();
        test_single();
        test_backpressure();
        test_nonowner();
        test_wrap();
        test_reset_mid();
        chk_cnt++; if (sb_q.size() !== 0) $display("FAIL scoreboard_drained: got %0d left exp 0", sb_q.size()); else pass_cnt++;
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
- Shares one combinational ALU_TOP datapath between two requesters, e.g. requester 0 = execute stage, requester 1 = branch/address unit.
- Accepts one operation at a time through a valid/ready handshake and grants requesters round-robin.
- Registers the operands, drives them into the ALU and captures the ALU result.
- Returns the result to the owning requester through a valid/ready response handshake.

Parameters:
DATA_WIDTH, 32, operand/result width
FUNC_WIDTH, 5, ALU control code width

Ports:
CLK  in  1  clock, rising edge
RST  in  1  asynchronous reset, active-high
Rn_VALID  in  1  request n (n=0,1) valid
Rn_READY  out  1  request n accepted this cycle
Rn_PC  in  DATA_WIDTH  request n PC operand
Rn_RS1  in  DATA_WIDTH  request n RS1 operand
Rn_RS2  in  DATA_WIDTH  request n RS2 operand
Rn_IMM  in  DATA_WIDTH  request n immediate
Rn_CTRL  in  FUNC_WIDTH  request n ALU function code
Rn_MUX1  in  1  request n operand-A select
Rn_MUX2  in  1  request n operand-B select
Rn_RSP_VALID  out  1  result for requester n valid
Rn_RSP_READY  in  1  requester n takes result
Rn_RSP_DATA  out  DATA_WIDTH  result, shared register, valid only with Rn_RSP_VALID
ALU_PC, ALU_RS1, ALU_RS2, ALU_IMM  out  DATA_WIDTH  to ALU_TOP operand inputs
ALU_CTRL  out  FUNC_WIDTH  to ALU_TOP ALU_CTRL
ALU_MUX1, ALU_MUX2  out  1  to ALU_TOP MUX1_CTRL/MUX2_CTRL
ALU_RESULT  in  DATA_WIDTH  from ALU_TOP ALU_OUT
BUSY  out  1  high when state is not IDLE

Behaviour:
- Clock and reset: one clock CLK; RST is asynchronous, active-high.
- Reset values: state IDLE; all ALU_* and Rn_RSP_DATA outputs 0; Rn_RSP_VALID 0; BUSY 0; round-robin pointer LAST=1, so R0 wins the first tie.
- FSM has three states: IDLE, EXEC, RESP. Only one operation is outstanding at a time.
- IDLE:
  - Grant is computed combinationally from R0_VALID, R1_VALID and LAST.
  - Both valid: grant the requester != LAST. One valid: grant it.
  - Rn_READY=1 only for the granted n, only in IDLE. READY never depends on RSP_READY.
  - On grant: latch operands, CTRL, MUX bits and OWNER=n into the ALU_* registers; LAST<=n; go to EXEC.
  - No valid: stay in IDLE.
- EXEC:
  - ALU_* outputs are stable from the registers for the whole cycle.
  - At the end of the cycle capture ALU_RESULT into the result register; go to RESP.
- RESP:
  - R[OWNER]_RSP_VALID=1; the other RSP_VALID=0. Both RSP_DATA ports show the result register.
  - Hold until R[OWNER]_RSP_READY=1, then go to IDLE.
  - The non-owner's RSP_READY is ignored.
- Latency and throughput:
  - Accept at edge N: ALU driven during cycle N+1, RSP_VALID high in cycle N+2.
  - Minimum 3 cycles per operation. No new accept in RESP or EXEC, even if the response completes the same cycle.
- Hold behaviour:
  - ALU_* outputs hold their last latched values outside EXEC and change only on accept.
  - The result register holds until the next EXEC.
- Request rule: a requester must hold VALID and its fields stable until READY. Dropping VALID before grant is legal; the request is simply not taken.
- Simultaneous events: requests arriving during EXEC/RESP wait. On return to IDLE, arbitration uses the updated LAST, so alternation is guaranteed under constant contention.
- Reset mid-operation: the operation is abandoned and no response is issued. FSM goes to IDLE, LAST=1, and all outputs take their reset values immediately (asynchronous).
- Width: the result is passed through unmodified. Wrap-around and sign interpretation are entirely the ALU's.

Test Plan:
- Single request: bench ALU model returns RS1+RS2 for CTRL=0. R0 sends RS1=20, RS2=30, CTRL=0, MUX=0/0; R0_RSP_READY=1 → R0_READY 1 cycle, R0_RSP_VALID exactly 2 cycles after accept with data 50, R1_RSP_VALID stays 0.
- Contention: R0 and R1 held valid continuously with distinct operands (R0: 1+2, R1: 10+20) → grant order R0, R1, R0, R1; responses 3, 30, 3, 30 each on the correct port; one accept every 3 cycles.
- Backpressure: R1 request accepted, R1_RSP_READY low for 5 cycles → RSP_VALID and data held 5 cycles; a pending R0 is not accepted until 1 cycle after R1_RSP_READY rises.
- Non-owner ready ignored: owner R0, R1_RSP_READY=1 and R0_RSP_READY=0 → FSM stays in RESP, BUSY stays 1.
- Reset mid-EXEC: assert RST during EXEC → BUSY, Rn_RSP_VALID and ALU_* are 0 immediately. After release with both valid, R0 is granted first and no stale response appears.
- Wrap/sign pass-through: RS1=0xFFFFFFFF, RS2=1, CTRL=0 → RSP_DATA 0x00000000.
